// File: rtl/reg_dump_scanner_if.sv
// Byte stream link from the register dump scanner to its sink (UART or debug link).
// The master drives outByte/outValid and the slave answers with outReady.
interface reg_dump_scanner_if;
    logic [7:0] outByte;
    logic       outValid;
    logic       outReady;

    modport master (output outByte, output outValid, input outReady);
    modport slave  (input outByte, input outValid, output outReady);
endinterface

// File: rtl/reg_dump_scanner.sv
// Walks a range of register-file indices through one read port and streams each word as a
// {101,index} header followed by the data bytes MSB first. REG_DUMP_CHECKSUM_EN appends an XOR checksum byte.
module reg_dump_scanner #(
    parameter int DATA_W = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [4:0]         firstReg,
    input  logic [4:0]         lastReg,
    output logic [4:0]         readRegister,
    input  logic [DATA_W-1:0]  readData,
    reg_dump_scanner_if.master stream,
    output logic               busy,
    output logic               done,
    output logic               regLED1,
    output logic               regLED2,
    output logic               regLED3,
    output logic               regLED4
);
    localparam int NBYTES = DATA_W / 8;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

`ifdef REG_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        CAPTURE = 3'd2,
        HDR     = 3'd3,
        DATA    = 3'd4,
        CSUM    = 3'd5,
        DONE    = 3'd6
    } stateT;
    logic [7:0]        csumR;
`else
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        CAPTURE = 3'd2,
        HDR     = 3'd3,
        DATA    = 3'd4,
        DONE    = 3'd6
    } stateT;
`endif

    stateT             stateR;
    logic [4:0]        indexR;
    logic [4:0]        lastRegR;
    logic [4:0]        readRegisterR;
    logic [DATA_W-1:0] shiftR;
    logic [CNT_W-1:0]  byteCntR;
    logic [7:0]        outByteR;
    logic              outValidR;
    logic              busyR;
    logic              doneR;
    logic [3:0]        ledR;
    logic              xferS;

    function automatic logic [7:0] headerByte(input logic [4:0] idx);
        return {3'b101, idx};
    endfunction

    assign xferS        = outValidR & stream.outReady;
    assign stream.outByte  = outByteR;
    assign stream.outValid = outValidR;
    assign readRegister = readRegisterR;
    assign busy         = busyR;
    assign done         = doneR;
    assign regLED1      = ledR[0];
    assign regLED2      = ledR[1];
    assign regLED3      = ledR[2];
    assign regLED4      = ledR[3];

    // Dump sequencer: address, capture, then header and data bytes under the valid/ready handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stateR        <= IDLE;
            indexR        <= 5'd0;
            lastRegR      <= 5'd0;
            readRegisterR <= 5'd0;
            shiftR        <= {DATA_W{1'b0}};
            byteCntR      <= {CNT_W{1'b0}};
            outByteR      <= 8'h00;
            outValidR     <= 1'b0;
            busyR         <= 1'b0;
            doneR         <= 1'b0;
            ledR          <= 4'hF;
`ifdef REG_DUMP_CHECKSUM_EN
            csumR         <= 8'h00;
`endif
        end else begin
            case (stateR)
                IDLE: begin
                    doneR     <= 1'b0;
                    outValidR <= 1'b0;
                    if (start) begin
                        indexR        <= firstReg;
                        lastRegR      <= lastReg;
                        readRegisterR <= firstReg;
                        busyR         <= 1'b1;
                        ledR          <= ~firstReg[3:0];
`ifdef REG_DUMP_CHECKSUM_EN
                        csumR         <= 8'h00;
`endif
                        stateR        <= ADDR;
                    end else begin
                        busyR <= 1'b0;
                        ledR  <= 4'hF;
                    end
                end
                ADDR: begin
                    shiftR <= readData;
                    stateR <= CAPTURE;
                end
                CAPTURE: begin
                    outByteR  <= headerByte(indexR);
                    outValidR <= 1'b1;
                    stateR    <= HDR;
                end
                HDR: begin
                    if (xferS) begin
`ifdef REG_DUMP_CHECKSUM_EN
                        csumR    <= csumR ^ outByteR;
`endif
                        outByteR <= shiftR[DATA_W-1 -: 8];
                        shiftR   <= {shiftR[DATA_W-9:0], 8'h00};
                        byteCntR <= {CNT_W{1'b0}};
                        stateR   <= DATA;
                    end
                end
                DATA: begin
                    if (xferS) begin
`ifdef REG_DUMP_CHECKSUM_EN
                        csumR <= csumR ^ outByteR;
`endif
                        if (byteCntR == CNT_W'(NBYTES - 1)) begin
                            if (indexR == lastRegR) begin
`ifdef REG_DUMP_CHECKSUM_EN
                                // The checksum byte covers this final data byte as well.
                                outByteR <= csumR ^ outByteR;
                                stateR   <= CSUM;
`else
                                outValidR <= 1'b0;
                                doneR     <= 1'b1;
                                stateR    <= DONE;
`endif
                            end else begin
                                outValidR     <= 1'b0;
                                indexR        <= indexR + 5'd1;
                                readRegisterR <= indexR + 5'd1;
                                ledR          <= ~(indexR[3:0] + 4'd1);
                                stateR        <= ADDR;
                            end
                        end else begin
                            outByteR <= shiftR[DATA_W-1 -: 8];
                            shiftR   <= {shiftR[DATA_W-9:0], 8'h00};
                            byteCntR <= byteCntR + CNT_W'(1);
                        end
                    end
                end
`ifdef REG_DUMP_CHECKSUM_EN
                CSUM: begin
                    if (xferS) begin
                        outValidR <= 1'b0;
                        doneR     <= 1'b1;
                        stateR    <= DONE;
                    end
                end
`endif
                DONE: begin
                    doneR     <= 1'b0;
                    busyR     <= 1'b0;
                    outValidR <= 1'b0;
                    ledR      <= 4'hF;
                    stateR    <= IDLE;
                end
                default: begin
                    outValidR <= 1'b0;
                    busyR     <= 1'b0;
                    doneR     <= 1'b0;
                    ledR      <= 4'hF;
                    stateR    <= IDLE;
                end
            endcase
        end
    end
endmodule
